// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// master = fetch stage, slave = memory/decode environment.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_fault;

  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc, id_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc, id_fault,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_stage.sv
// RISC-V instruction fetch: PC owner, single-outstanding imem requester, IF/ID register with skid.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets instead of aligning them.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic     clk,
  input  logic     reset,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DROP = 2'b11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        fault_q, fault_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        req_s;
  logic        grant_s;
  logic        accept_s;
  logic        out_free_s;
  logic        misalign_s;
  logic [31:0] target_s;

  // A full skid buffer blocks new requests so at most two fetched words are ever held.
  assign req_s      = (state_q == S_REQ) && !skid_valid_q;
  assign grant_s    = req_s && bus.imem_gnt;
  assign accept_s   = (state_q == S_WAIT) && bus.imem_rvalid;
  assign out_free_s = !id_valid_q || bus.id_ready;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misalign_s = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign target_s   = bus.redirect_pc;
`else
  assign misalign_s = 1'b0;
  assign target_s   = {bus.redirect_pc[31:2], 2'b00};
`endif

  assign bus.imem_req  = req_s;
  assign bus.imem_addr = pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_pc     = id_pc_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign bus.id_fault  = fault_q;
`else
  assign bus.id_fault  = 1'b0;
`endif

  // Fetch FSM next state and PC bookkeeping; redirect overrides the normal transition.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        if (fault_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (grant_s) begin
          pc_d     = pc_q + 32'd4;
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_REQ;
        end
      end
      S_WAIT, S_DROP: begin
        if (bus.imem_rvalid) begin
          state_d = S_REQ;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect_valid) begin
      if (misalign_s) begin
        fault_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        fault_d = 1'b0;
        pc_d    = target_s;
        // An already-granted or still-outstanding request must have its response dropped.
        case (state_q)
          S_IDLE: state_d = S_REQ;
          S_REQ: begin
            if (grant_s) begin
              state_d = S_DROP;
            end else begin
              state_d = S_REQ;
            end
          end
          S_WAIT, S_DROP: begin
            if (bus.imem_rvalid) begin
              state_d = S_REQ;
            end else begin
              state_d = S_DROP;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else begin
      fault_d = fault_q;
    end
  end

  // IF/ID register and skid buffer: flush beats stall, skid drains before fresh data.
  always_comb begin
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (bus.redirect_valid) begin
      skid_valid_d = 1'b0;
      id_inst_d    = NOP_INST;
      if (misalign_s) begin
        id_valid_d = 1'b1;
        id_pc_d    = bus.redirect_pc;
      end else begin
        id_valid_d = 1'b0;
      end
    end else if (fault_q) begin
      id_valid_d = id_valid_q;
    end else if (out_free_s) begin
      if (skid_valid_q) begin
        id_valid_d   = 1'b1;
        id_inst_d    = skid_inst_q;
        id_pc_d      = skid_pc_q;
        skid_valid_d = accept_s;
        if (accept_s) begin
          skid_inst_d = bus.imem_rdata;
          skid_pc_d   = req_pc_q;
        end else begin
          skid_inst_d = skid_inst_q;
        end
      end else if (accept_s) begin
        id_valid_d = 1'b1;
        id_inst_d  = bus.imem_rdata;
        id_pc_d    = req_pc_q;
      end else begin
        id_valid_d = 1'b0;
        id_inst_d  = NOP_INST;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = bus.imem_rdata;
      skid_pc_d    = req_pc_q;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      fault_q      <= 1'b0;
      id_valid_q   <= 1'b0;
      id_inst_q    <= NOP_INST;
      id_pc_q      <= 32'h0000_0000;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      fault_q      <= fault_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Scoreboard bench for ifetch_stage: randomized memory/decode/redirect stimulus vs a program-order model.
`timescale 1ns/1ps
module tb_ifetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_if bus();

  ifetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // stimulus knobs and memory model state
  int          gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
  int          lat_min = 0, lat_max = 0;
  bit          pend_valid = 1'b0;
  logic [31:0] pend_addr;
  int          pend_wait = 0;
  int          redir_mode = 0;
  logic [31:0] redir_tgt = 32'h0;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_gnt_q[$];
  bit          mon_en = 1'b0;
  bit          chk_flush = 1'b0;
  bit          chk_fault = 1'b0;
  bit          in_fault = 1'b0;
  logic [31:0] fault_pc = 32'h0;
  int          consumed = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h00A0_0113;
    else if (a == 32'h0000_0008) return 32'h0000_0013;
    else return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  function automatic logic [31:0] pick_target();
    int unsigned k;
    k = $urandom_range(3, 0);
    case (k)
      0: return 32'h0000_0100;
      1: return 32'hFFFF_FFF8;
`ifdef IFETCH_MISALIGN_CHECK_EN
      2: return 32'h0000_0204;
`else
      2: return 32'h0000_0102;
`endif
      default: return $urandom() & 32'h0000_FFFC;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drive inputs for the coming cycle, just after the rising edge
  task automatic step();
    bit fire;
    @(posedge clk);
    #1;
    if (pend_valid && pend_wait == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = memfn(pend_addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
      if (pend_valid) pend_wait--;
    end
    bus.imem_gnt = ($urandom_range(99, 0) < gnt_pct);
    bus.id_ready = ($urandom_range(99, 0) < rdy_pct);
    case (redir_mode)
      1: fire = pend_valid && !bus.imem_rvalid;
      2: fire = bus.imem_rvalid;
      3: fire = 1'b1;
      default: fire = 1'b0;
    endcase
    if (fire) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = redir_tgt;
      if (redir_mode == 2) bus.id_ready = 1'b0;
      redir_mode = 0;
    end else if (redir_pct != 0 && $urandom_range(99, 0) < redir_pct) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pick_target();
    end else begin
      bus.redirect_valid = 1'b0;
    end
  endtask

  task automatic tick();
    step();
    @(negedge clk);
    #1;
  endtask

  task automatic fire_redirect(input int mode, input logic [31:0] tgt, input string name);
    redir_tgt  = tgt;
    redir_mode = mode;
    for (int i = 0; i < 100 && redir_mode != 0; i++) tick();
    if (redir_mode != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: redirect not issued within 100 cycles", name);
      redir_mode = 0;
    end
  endtask

  task automatic expect_grants(input logic [31:0] a0, input logic [31:0] a1, input string name);
    exp_gnt_q.push_back(a0);
    exp_gnt_q.push_back(a1);
    for (int i = 0; i < 100 && exp_gnt_q.size() != 0; i++) tick();
    if (exp_gnt_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d grants outstanding expected 0", name, exp_gnt_q.size());
      exp_gnt_q.delete();
    end
  endtask

  // monitor: memory bookkeeping, protocol checks and in-order delivery scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] t;
    if (!reset && mon_en) begin
      if (chk_flush) begin
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
        chk("flush_inst", bus.id_inst, NOP);
        chk("flush_fault", {31'd0, bus.id_fault}, 32'd0);
        chk_flush = 1'b0;
      end
      if (chk_fault) begin
        chk("fault_flag", {31'd0, bus.id_fault}, 32'd1);
        chk("fault_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("fault_inst", bus.id_inst, NOP);
        chk("fault_pc", bus.id_pc, fault_pc);
        chk_fault = 1'b0;
      end
      if (bus.imem_req) begin
        chk("one_outstanding", {31'd0, pend_valid}, 32'd0);
        chk("addr_aligned", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      end
      if (bus.imem_rvalid) pend_valid = 1'b0;
      if (bus.imem_req && bus.imem_gnt) begin
        pend_valid = 1'b1;
        pend_addr  = bus.imem_addr;
        pend_wait  = int'($urandom_range(lat_max, lat_min));
        if (exp_gnt_q.size() != 0) chk("gnt_addr", bus.imem_addr, exp_gnt_q.pop_front());
      end
      if (bus.id_valid && bus.id_ready && !in_fault) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.id_pc, 32'hXXXX_XXXX);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", bus.id_pc, e);
          chk("id_inst", bus.id_inst, memfn(e));
          exp_q.push_back(e + 32'd4);
          consumed++;
        end
      end
      if (bus.redirect_valid) begin
        t = bus.redirect_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin
          in_fault  = 1'b1;
          chk_fault = 1'b1;
          fault_pc  = t;
        end else begin
          in_fault  = 1'b0;
          exp_q.delete();
          exp_q.push_back(t);
          chk_flush = 1'b1;
        end
`else
        exp_q.delete();
        exp_q.push_back({t[31:2], 2'b00});
        chk_flush = 1'b1;
`endif
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    reset = 1'b1;
    exp_q.push_back(32'h0000_0000);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_inst", bus.id_inst, NOP);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_fault", {31'd0, bus.id_fault}, 32'd0);

    // immediate grant, one-cycle response, decode always ready
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("idle_no_req", {31'd0, bus.imem_req}, 32'd0);
    mon_en = 1'b1;
    vcnt = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 1) begin
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
      end
      if (i == 3) chk("first_valid", {31'd0, bus.id_valid}, 32'd1);
      if (i == 4) chk("pulse_gap", {31'd0, bus.id_valid}, 32'd0);
      if (bus.id_valid) vcnt++;
    end
    chk("throughput", vcnt, 32'd10);

    // decode stall: output and skid fill, requests stop, nothing lost
    rdy_pct = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 6) begin
        chk("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
        chk("stall_valid", {31'd0, bus.id_valid}, 32'd1);
        chk("stall_pc", bus.id_pc, exp_q[0]);
        chk("stall_inst", bus.id_inst, memfn(exp_q[0]));
      end
    end
    rdy_pct = 100;
    repeat (6) tick();

    // redirect while waiting for data
    lat_min = 2; lat_max = 2;
    fire_redirect(1, 32'h0000_0100, "redir_wait");
    expect_grants(32'h0000_0100, 32'h0000_0104, "redir_wait_gnt");
    lat_min = 0; lat_max = 0;

    // redirect in the same cycle as returning data with decode stalled
    fire_redirect(2, 32'h0000_0300, "redir_rvalid");
    expect_grants(32'h0000_0300, 32'h0000_0304, "redir_rvalid_gnt");

    // PC wraps at the top of the address space
    lat_min = 2; lat_max = 2;
    fire_redirect(1, 32'hFFFF_FFFC, "redir_wrap");
    expect_grants(32'hFFFF_FFFC, 32'h0000_0000, "wrap_gnt");

`ifdef IFETCH_MISALIGN_CHECK_EN
    fire_redirect(1, 32'h0000_0102, "redir_misalign");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fault_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    lat_min = 0; lat_max = 0;
    fire_redirect(3, 32'h0000_0200, "redir_clear");
    expect_grants(32'h0000_0200, 32'h0000_0204, "clear_gnt");
`else
    fire_redirect(1, 32'h0000_0102, "redir_misalign");
    expect_grants(32'h0000_0100, 32'h0000_0104, "misalign_gnt");
    lat_min = 0; lat_max = 0;
`endif

    // randomized traffic
    gnt_pct = 70; rdy_pct = 70; redir_pct = 4; lat_min = 0; lat_max = 3;
    repeat (3000) tick();
    redir_pct = 0; rdy_pct = 100;
    repeat (20) tick();
    chk("progress", {31'd0, (consumed >= 100)}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
